// File: rtl/mio_wait_mem.sv
// Word-addressed RAM responder for the multi-cycle CPU bus: programmable wait states,
// out-of-range error reporting and a side-band preload port.
module mio_wait_mem #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 32,
    parameter int                 DEPTH_LOG2  = 6,
    parameter int                 WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter logic [DATA_W-1:0]  ERR_DATA    = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  err,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [DATA_W-1:0]     init_data,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(4) << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic                    oor_q, oor_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    ready_q, err_q, busy_q;

    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0]       off;
    logic                    in_oor;
    logic [DEPTH_LOG2-1:0]   in_idx;
    logic                    cur_we, cur_oor;
    logic [DEPTH_LOG2-1:0]   cur_idx;

    // Offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land out of range.
    assign off    = addr - BASE_ADDR;
    assign in_oor = (off >= SPAN);
    assign in_idx = off[DEPTH_LOG2+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cur_we  = we_q;
        cur_oor = oor_q;
        cur_idx = idx_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    oor_d   = in_oor;
                    idx_d   = in_idx;
                    wdata_d = wdata;
                    cnt_d   = CNT_LOAD;
                    cur_we  = we;
                    cur_oor = in_oor;
                    cur_idx = in_idx;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Read data is captured on the edge entering RESP so it lines up with ready.
        if (state_d == S_RESP && !cur_we) begin
            rdata_d = cur_oor ? ERR_DATA : mem_q[cur_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= (state_d == S_RESP);
            err_q   <= (state_d == S_RESP) && cur_oor;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        oor_q   <= oor_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // CPU commit is written last so it wins over a same-edge preload to the same word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we) begin
                mem_q[init_addr] <= init_data;
            end
            if (state_q == S_RESP && we_q && !oor_q) begin
                mem_q[idx_q] <= wdata_q;
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mio_wait_mem.sv
// Bench for mio_wait_mem: two instances (2 wait states at base 0, zero wait states at base 0x400)
// checked against a word-array model of the memory.
module tb_mio_wait_mem;

    localparam int          WA     = 2;
    localparam int          WB     = 0;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0400;
    localparam logic [31:0] ERRD   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_we;
    logic [5:0]  init_addr;
    logic [31:0] init_data;

    logic        req_a, we_a, ready_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ready_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_a [64];
    logic [31:0] ref_b [64];
    logic [31:0] last_a, last_b;
    logic [31:0] plist [8] = '{32'h2009000A, 32'h200AFFFB, 32'h152A0000, 32'h00004020,
                               32'h35280000, 32'h39280000, 32'h3C0B0006, 32'h0C000002};

    always #5 clk = ~clk;

    mio_wait_mem #(.WAIT_CYCLES(WA), .BASE_ADDR(BASE_A)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ready(ready_a), .err(err_a), .init_we(init_we),
        .init_addr(init_addr), .init_data(init_data), .busy(busy_a));

    mio_wait_mem #(.WAIT_CYCLES(WB), .BASE_ADDR(BASE_B)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ready(ready_b), .err(err_b), .init_we(init_we),
        .init_addr(init_addr), .init_data(init_data), .busy(busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_ready(input bit sel);
        return sel ? {31'b0, ready_b} : {31'b0, ready_a};
    endfunction
    function automatic logic [31:0] o_err(input bit sel);
        return sel ? {31'b0, err_b} : {31'b0, err_a};
    endfunction
    function automatic logic [31:0] o_busy(input bit sel);
        return sel ? {31'b0, busy_b} : {31'b0, busy_a};
    endfunction
    function automatic logic [31:0] o_rdata(input bit sel);
        return sel ? rdata_b : rdata_a;
    endfunction

    function automatic logic [31:0] rand_addr(input logic [31:0] base);
        int r = int'($urandom_range(0, 9));
        logic [31:0] a;
        if (r < 7)       a = base + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        else if (r == 7) a = $urandom;
        else if (r == 8) a = base - 32'($urandom_range(1, 16));
        else             a = base + 32'd256 + 32'($urandom_range(0, 255));
        return a;
    endfunction

    task automatic preload(input int ix, input logic [31:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = 6'(ix); init_data = d;
        @(posedge clk); #1;
        init_we = 1'b0;
        ref_a[ix] = d;
        ref_b[ix] = d;
    endtask

    // pmode: 0 none, 1 preload during first wait cycle (instance A only), 2 preload on commit edge
    task automatic txn(input bit sel, input bit w, input logic [31:0] ad, input logic [31:0] wd,
                       input int pmode, input int pidx, input logic [31:0] pdata);
        logic [31:0] offs, exp_rd;
        bit oor;
        int ix, n, lat;
        offs = ad - (sel ? BASE_B : BASE_A);
        oor  = (offs >= 32'd256);
        ix   = oor ? 0 : int'(offs >> 2);
        lat  = (sel ? WB : WA) + 1;
        if (pmode == 1) begin
            ref_a[pidx] = pdata;
            ref_b[pidx] = pdata;
        end
        if (w) exp_rd = sel ? last_b : last_a;
        else   exp_rd = oor ? ERRD : (sel ? ref_b[ix] : ref_a[ix]);

        @(negedge clk);
        if (sel) begin req_b = 1'b1; we_b = w; addr_b = ad; wdata_b = wd; end
        else     begin req_a = 1'b1; we_a = w; addr_a = ad; wdata_a = wd; end
        @(posedge clk); #1;
        if (sel) begin req_b = 1'b0; addr_b = $urandom; wdata_b = $urandom; end
        else     begin req_a = 1'b0; addr_a = $urandom; wdata_a = $urandom; end
        if (pmode == 1) begin
            init_we = 1'b1; init_addr = 6'(pidx); init_data = pdata;
        end
        n = 1;
        while (o_ready(sel) == 32'd0 && n < 20) begin
            @(posedge clk); #1;
            init_we = 1'b0;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("ready_pulse", o_ready(sel), 32'd1);
        chk("err_with_ready", o_err(sel), 32'(oor));
        chk("rdata_at_ready", o_rdata(sel), exp_rd);
        chk("busy_in_resp", o_busy(sel), 32'd1);

        if (pmode == 2) begin
            init_we = 1'b1; init_addr = 6'(pidx); init_data = pdata;
            ref_a[pidx] = pdata;
            ref_b[pidx] = pdata;
        end
        if (w && !oor) begin
            if (sel) ref_b[ix] = wd; else ref_a[ix] = wd;
        end
        if (!w) begin
            if (sel) last_b = exp_rd; else last_a = exp_rd;
        end
        @(posedge clk); #1;
        init_we = 1'b0;
        chk("ready_one_cycle", o_ready(sel), 32'd0);
        chk("err_one_cycle", o_err(sel), 32'd0);
        chk("busy_after", o_busy(sel), 32'd0);
        chk("rdata_hold", o_rdata(sel), exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation bound expired");
    end

    initial begin
        bit          s, w, saw;
        int          pm, pi;
        logic [31:0] ad, offs;

        reset = 1'b1; init_we = 1'b0; init_addr = '0; init_data = '0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        last_a = '0; last_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", o_ready(0), 32'd0);
        chk("rst_err_a", o_err(0), 32'd0);
        chk("rst_busy_a", o_busy(0), 32'd0);
        chk("rst_rdata_a", o_rdata(0), 32'd0);
        chk("rst_ready_b", o_ready(1), 32'd0);
        chk("rst_rdata_b", o_rdata(1), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) preload(i, (i < 8) ? plist[i] : $urandom);

        txn(0, 0, 32'h1C, 32'h0, 0, 0, 32'h0);

        // Zero wait states, req held high, address stepped every response.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b0; addr_b = BASE_B;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("b2b_ready", o_ready(1), 32'd1);
            chk("b2b_rdata", o_rdata(1), ref_b[k]);
            chk("b2b_err", o_err(1), 32'd0);
            addr_b = BASE_B + 32'(4 * (k + 1));
            if (k == 2) req_b = 1'b0;
            @(posedge clk); #1;
            chk("b2b_gap", o_ready(1), 32'd0);
        end
        last_b = ref_b[2];

        txn(0, 1, 32'h10, 32'h12345678, 0, 0, 32'h0);
        txn(0, 0, 32'h10, 32'h0, 0, 0, 32'h0);
        txn(0, 0, 32'h13, 32'h0, 0, 0, 32'h0);
        txn(0, 0, 32'h100, 32'h0, 0, 0, 32'h0);
        txn(0, 1, 32'h100, 32'hCAFEF00D, 0, 0, 32'h0);
        txn(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        txn(1, 0, BASE_B - 32'd4, 32'h0, 0, 0, 32'h0);

        // Abort a write to 0x8 from WAIT; a preload during reset must also be dropped.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h8; wdata_a = 32'h5555AAAA;
        @(posedge clk); #1;
        req_a = 1'b0;
        chk("busy_in_wait", o_busy(0), 32'd1);
        reset = 1'b1; init_we = 1'b1; init_addr = 6'd2; init_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        reset = 1'b0; init_we = 1'b0;
        chk("abort_ready", o_ready(0), 32'd0);
        chk("abort_err", o_err(0), 32'd0);
        chk("abort_busy", o_busy(0), 32'd0);
        chk("abort_rdata", o_rdata(0), 32'd0);
        last_a = '0; last_b = '0;
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready_a) saw = 1'b1;
        end
        chk("abort_no_ready", 32'(saw), 32'd0);
        txn(0, 0, 32'h8, 32'h0, 0, 0, 32'h0);

        txn(0, 1, 32'hC, 32'hBBBBBBBB, 2, 3, 32'hAAAAAAAA);
        txn(0, 0, 32'hC, 32'h0, 0, 0, 32'h0);
        txn(1, 0, BASE_B + 32'hC, 32'h0, 0, 0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            s  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 2) == 0);
            ad = rand_addr(s ? BASE_B : BASE_A);
            pm = 0;
            pi = int'($urandom_range(0, 63));
            if (!s && $urandom_range(0, 3) == 0) begin
                pm   = 1;
                offs = ad - BASE_A;
                if (offs < 32'd256 && $urandom_range(0, 1) == 1) pi = int'(offs >> 2);
            end
            if ($urandom_range(0, 5) == 0) preload(int'($urandom_range(0, 63)), $urandom);
            txn(s, w, ad, $urandom, pm, pi, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
